// File: rtl/addr_mem_reader_if.sv
// rtl/addr_mem_reader_if.sv - address, RAM and data stream bundle for addr_mem_reader
interface addr_mem_reader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              addr_valid;
  logic              addr_ready;
  logic [ADDR_W-1:0] addr;
  logic              store;

  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  logic              data_valid;
  logic              data_ready;
  logic [DATA_W-1:0] data;

  modport slave (
    input  addr_valid, addr, store, mem_rdata, data_ready,
    output addr_ready, mem_en, mem_addr, data_valid, data
  );

  modport master (
    output addr_valid, addr, store, mem_rdata, data_ready,
    input  addr_ready, mem_en, mem_addr, data_valid, data
  );
endinterface

// File: rtl/addr_mem_reader.sv
// rtl/addr_mem_reader.sv - issues RAM reads for an address stream, 2-entry FIFO hides read latency
module addr_mem_reader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic gen_done_i,
  output logic done_o,
  addr_mem_reader_if.slave bus
);

  logic [1:0]        count_q, count_d;
  logic              inflight_q;
  logic              keep_q;
  logic              rd_ptr_q;
  logic              wr_ptr_q;
  logic              done_q, done_d;
  logic [DATA_W-1:0] fifo_q [2];
  logic [ADDR_W-1:0] addr_w;

  logic pop;
  logic push;
  logic accept;

  assign bus.data_valid = (count_q != 2'd0);
  assign bus.data       = fifo_q[rd_ptr_q];
  assign pop            = bus.data_valid & bus.data_ready;

  // A read in flight already owns a FIFO slot, so it counts against the credit.
  assign bus.addr_ready = ((count_q + {1'b0, inflight_q}) < 2'd2) | pop;
  assign accept         = bus.addr_valid & bus.addr_ready;

  assign addr_w       = bus.addr;
  assign bus.mem_en   = accept;
  assign bus.mem_addr = addr_w;

  assign push   = inflight_q & keep_q;
  assign done_o = done_q;

  always_comb begin
    count_d = count_q + {1'b0, push} - {1'b0, pop};
    done_d  = done_q;
    if (run_i) begin
      done_d = 1'b0;
    end else if (gen_done_i && !inflight_q && (count_q == 2'd0)) begin
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
      keep_q     <= 1'b0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      count_q    <= count_d;
      inflight_q <= accept;
      keep_q     <= bus.store;
      done_q     <= done_d;
      if (push) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  // Storage needs no reset; count_q alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      fifo_q[wr_ptr_q] <= bus.mem_rdata;
    end
  end

endmodule

// File: doc/addr_mem_reader.md
# addr_mem_reader

Read stage directly downstream of the address generator. It consumes the generator's valid/ready address stream and issues reads to a synchronous single-port RAM with 1-cycle read latency. A 2-entry output FIFO absorbs that latency, so the block sustains one word per cycle under full-rate handshakes and stalls cleanly under back-pressure. It also reports completion once the generator is done and every issued read has drained.

## Interface
Parameters:
- ADDR_W, 10, RAM address width (matches generator address width)
- DATA_W, 8, RAM data width

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- run_i  in  1  single-cycle start pulse; clears done_o
- addr_valid_i  in  1  generator address valid
- addr_ready_o  out  1  block accepts address this cycle
- addr_i  in  ADDR_W  read address
- store_i  in  1  1: forward the read word; 0: perform the read, discard the word
- gen_done_i  in  1  generator finished, no further addresses
- mem_en_o  out  1  RAM read enable
- mem_addr_o  out  ADDR_W  RAM address
- mem_rdata_i  in  DATA_W  RAM read data, valid the cycle after mem_en_o
- data_valid_o  out  1  FIFO head valid
- data_ready_i  in  1  consumer accepts head
- data_o  out  DATA_W  FIFO head word
- done_o  out  1  generator done and pipeline empty (sticky)

## Operation
- State:
  - inflight (1 bit): read issued last cycle
  - inflight_keep (1 bit): store_i of that read
  - 2-entry FIFO: count 0..2, rd/wr pointers, 1-bit each
  - done register
- pop = data_valid_o & data_ready_i; data_valid_o = (count != 0); data_o = FIFO head.
- addr_ready_o = ((count + inflight) < 2) | pop. This path is combinational from data_ready_i.
- accept = addr_valid_i & addr_ready_o. Then:
  - mem_en_o = accept
  - mem_addr_o = addr_i, passed through combinationally
  - inflight_next = accept, inflight_keep_next = store_i
- Capture: when inflight & inflight_keep, mem_rdata_i is written to the FIFO tail at the end of that cycle.
  - When inflight & ~inflight_keep, nothing is written, but the slot was still reserved.
- Count update:
  - count_next = count + push − pop
  - Simultaneous push and pop at count 2 cannot occur, because the credit rule forbids it.
  - Simultaneous push and pop at count 1 keeps count at 1.
- Credit rule: count + inflight ≤ 2 always. The FIFO never overflows and never drops a kept word.
- Done handling:
  - done register sets when gen_done_i & ~inflight & (count == 0).
  - It stays set until run_i or rst_i; run_i has priority over set in the same cycle.
  - done_o = done register.
- Reset:
  - count = 0, inflight = 0, pointers = 0, done = 0.
  - Outputs after reset: addr_ready_o = 1, mem_en_o = 0 (addr_valid_i low), data_valid_o = 0, done_o = 0.
  - data_o is don't-care while data_valid_o = 0.
- Reset mid-operation: any in-flight read and all FIFO contents are discarded. The next cycle behaves exactly as after power-up.
- run_i does not flush the FIFO; it only clears done.

## Timing
- Address accepted in cycle N:
  - RAM is read in cycle N.
  - Word is captured at the end of N+1.
  - data_valid_o rises in N+2, so latency is 2 cycles from accept to data_valid_o.
- Throughput: 1 accept per cycle while data_ready_i = 1 continuously.
- Back-pressure: with data_ready_i = 0, at most 2 addresses are accepted beyond the last pop; addr_ready_o then drops.
  - Example from empty: accept at N and N+1, addr_ready_o = 0 from N+2.
- data_o and data_valid_o hold stable while data_valid_o & ~data_ready_i.
- done_o rises no earlier than the cycle after the last kept word is popped (or after the last discarded read completes).

## Test plan
- Streaming:
  - Stimulus: RAM mem[a] = a ^ 8'h5A; addresses 0..7 back-to-back, store_i = 1, data_ready_i = 1.
  - Required: data_o = 5A, 5B, 58, 59, 5E, 5F, 5C, 5D on consecutive cycles, first one 2 cycles after the first accept; addr_ready_o never drops.
- Back-pressure:
  - Stimulus: same stream, data_ready_i = 0 for cycles 2..6.
  - Required: exactly 2 accepts while stalled, addr_ready_o = 0 otherwise; after release all 8 words arrive in order with no loss or duplication.
- Discard:
  - Stimulus: addresses 0..3 with store_i = 1, 0, 1, 0.
  - Required: mem_en_o pulses 4 times; only 5A and 58 appear on data_o.
- Done:
  - Stimulus: gen_done_i asserted in the same cycle as the last accept.
  - Required: done_o stays 0 until the FIFO is empty, then goes 1 and stays 1; a run_i pulse returns it to 0 next cycle.
- Reset mid-stream:
  - Stimulus: rst_i for 1 cycle while count = 2 and inflight = 1.
  - Required: next cycle data_valid_o = 0, addr_ready_o = 1, done_o = 0; a new stream from address 4 yields 5E first.
- Random:
  - Stimulus: random addr_valid_i, data_ready_i and store_i over 1000 cycles.
  - Required: data_o sequence equals the scoreboard of kept reads; count + inflight ≤ 2 every cycle.
